// File: rtl/test_status_pkg.sv
// Shared types for the test status monitor.
//   status_e : RUN/PASS/FAIL/TIMEOUT encoding driven on the status port.
//   mode_e   : selects which completion source(s) the monitor listens to.
//   idxWidth : width of the hit_index port. It is sized for the longer
//              address list, with a floor of 2 entries so it is never 0 bits.
package test_status_pkg;

  typedef enum logic [1:0] {
    STATUS_RUN     = 2'd0,
    STATUS_PASS    = 2'd1,
    STATUS_FAIL    = 2'd2,
    STATUS_TIMEOUT = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    MODE_PC     = 2'd0,
    MODE_TOHOST = 2'd1,
    MODE_BOTH   = 2'd2
  } mode_e;

  localparam int unsigned CYCLE_W = 32;

  function automatic int unsigned idxWidth(input int unsigned nPass, input int unsigned nFail);
    int unsigned m;
    m = (nPass > nFail) ? nPass : nFail;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/tsm_addr_match.sv
// Compares one address against a packed list of N addresses.
//   list  : N x XLEN packed list. Entry i is list[i*XLEN +: XLEN].
//   addr  : address under test.
//   hit   : at least one entry equals addr.
//   index : lowest matching entry. It is 0 when nothing matches.
module tsm_addr_match #(
  parameter int unsigned N    = 2,
  parameter int unsigned XLEN = 32
) (
  input  logic [N*XLEN-1:0]                 list,
  input  logic [XLEN-1:0]                   addr,
  output logic                              hit,
  output logic [$clog2((N > 1) ? N : 2)-1:0] index
);

  localparam int IW = $clog2((N > 1) ? N : 2);

  // The loop scans from the top entry down, so the last write wins.
  // That makes the lowest matching entry the one reported.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (list[i*XLEN +: XLEN] == addr) begin
        hit   = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/test_status_monitor.sv
// Watches a core's retire stream and store port, and decides when a test
// program has ended.
// Ports:
//   clk, reset       : rising-edge clock and synchronous active-low reset.
//   retire, pc       : the instruction at pc commits this cycle.
//   mem_write, data_addr, write_data : store strobe, address and data.
//   status, done     : registered RUN/PASS/FAIL/TIMEOUT. done = (status != RUN).
//   hit_index        : lowest matching list entry for a PC ending, else 0.
//   fail_code        : write_data >> 1 from a failing tohost store.
//   cycle_count      : cycles spent in RUN. Saturating, and frozen once terminal.
//   last_pc          : PC of the last instruction retired while in RUN.
// Handshake: none. retire and mem_write are single-cycle strobes sampled on
// every rising edge. No backpressure exists, and every strobe seen in RUN is
// acted on.
module test_status_monitor
  import test_status_pkg::*;
#(
  parameter int unsigned              XLEN           = 32,
  parameter int unsigned              N_PASS         = 2,
  parameter int unsigned              N_FAIL         = 2,
  parameter logic [N_PASS*XLEN-1:0]   PASS_ADDRS     = {32'h14, 32'h14},
  parameter logic [N_FAIL*XLEN-1:0]   FAIL_ADDRS     = {32'h4C, 32'h4C},
  parameter logic [XLEN-1:0]          TOHOST_ADDR    = 32'h0000_1000,
  parameter mode_e                    MODE           = MODE_BOTH,
  parameter int unsigned              TIMEOUT_CYCLES = 70,
  localparam int unsigned             IDX_W          = idxWidth(N_PASS, N_FAIL)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               retire,
  input  logic [XLEN-1:0]    pc,
  input  logic               mem_write,
  input  logic [XLEN-1:0]    data_addr,
  input  logic [XLEN-1:0]    write_data,
  output logic [1:0]         status,
  output logic               done,
  output logic [IDX_W-1:0]   hit_index,
  output logic [XLEN-1:0]    fail_code,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [XLEN-1:0]    last_pc
);

  localparam int unsigned PIW = $clog2((N_PASS > 1) ? N_PASS : 2);
  localparam int unsigned FIW = $clog2((N_FAIL > 1) ? N_FAIL : 2);

  localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CYCLE_W-1:0] TIMEOUT_LAST =
    TIMEOUT_EN ? CYCLE_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [XLEN-1:0]  TOHOST_PASS  = XLEN'(1);

  status_e             stateQ, stateD;
  logic [IDX_W-1:0]    hitIdxQ, hitIdxD;
  logic [XLEN-1:0]     failCodeQ, failCodeD;
  logic [CYCLE_W-1:0]  cycleQ;
  logic [XLEN-1:0]     lastPcQ;

  logic                passHit, failHit;
  logic [PIW-1:0]      passIdx;
  logic [FIW-1:0]      failIdx;

  tsm_addr_match #(.N(N_PASS), .XLEN(XLEN)) passMatch (
    .list  (PASS_ADDRS),
    .addr  (pc),
    .hit   (passHit),
    .index (passIdx)
  );

  tsm_addr_match #(.N(N_FAIL), .XLEN(XLEN)) failMatch (
    .list  (FAIL_ADDRS),
    .addr  (pc),
    .hit   (failHit),
    .index (failIdx)
  );

  logic pcValid, pcPass, pcFail;
  logic thValid, thPass, thFail;
  logic timeoutHit;

  always_comb begin
    pcValid    = retire && (MODE != MODE_TOHOST);
    pcPass     = pcValid && passHit;
    pcFail     = pcValid && failHit;
    thValid    = mem_write && (data_addr == TOHOST_ADDR) && (MODE != MODE_PC);
    thPass     = thValid && (write_data == TOHOST_PASS);
    // A tohost value of 0 means nothing, so only nonzero values other than 1 fail.
    thFail     = thValid && (write_data != '0) && (write_data != TOHOST_PASS);
    timeoutHit = TIMEOUT_EN && (cycleQ == TIMEOUT_LAST);
  end

  // Next-state logic. Terminal states hold, so every input is ignored there.
  // Priority is fail > pass > timeout. If a PC fail and a tohost fail land
  // together, the PC index and the tohost code are both kept.
  always_comb begin
    stateD    = stateQ;
    hitIdxD   = hitIdxQ;
    failCodeD = failCodeQ;
    unique case (stateQ)
      STATUS_RUN: begin
        if (pcFail || thFail) begin
          stateD    = STATUS_FAIL;
          hitIdxD   = pcFail ? IDX_W'(failIdx) : '0;
          failCodeD = thFail ? (write_data >> 1) : '0;
        end else if (pcPass || thPass) begin
          stateD  = STATUS_PASS;
          hitIdxD = pcPass ? IDX_W'(passIdx) : '0;
        end else if (timeoutHit) begin
          stateD  = STATUS_TIMEOUT;
          hitIdxD = '0;
        end
      end
      default: begin
        stateD = stateQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ    <= STATUS_RUN;
      hitIdxQ   <= '0;
      failCodeQ <= '0;
      cycleQ    <= '0;
      lastPcQ   <= '0;
    end else begin
      stateQ    <= stateD;
      hitIdxQ   <= hitIdxD;
      failCodeQ <= failCodeD;
      // Count only while staying in RUN. The value at the ending edge
      // is the one that gets frozen.
      if ((stateQ == STATUS_RUN) && (stateD == STATUS_RUN) && (cycleQ != '1)) begin
        cycleQ <= cycleQ + 1'b1;
      end
      if ((stateQ == STATUS_RUN) && retire) begin
        lastPcQ <= pc;
      end
    end
  end

  assign status      = stateQ;
  assign done        = (stateQ != STATUS_RUN);
  assign hit_index   = hitIdxQ;
  assign fail_code   = failCodeQ;
  assign cycle_count = cycleQ;
  assign last_pc     = lastPcQ;

endmodule

// File: tb/tb_test_status_monitor.sv
// Bench for test_status_monitor.
// Instance dut uses the default parameters.
// Instance dut2 runs in PC-only mode with no timeout and pass list {0x30, 0x14}.
module tb_test_status_monitor;

  localparam int W = 99;  // {status[2], hit[1], fail_code[32], cycle_count[32], last_pc[32]}

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_PASS    = 2'd1;
  localparam logic [1:0] S_FAIL    = 2'd2;
  localparam logic [1:0] S_TIMEOUT = 2'd3;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        retire = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] write_data = '0;

  always #5 clk = ~clk;

  logic [1:0]  status, status2;
  logic        done, done2;
  logic        hit_index, hit_index2;
  logic [31:0] fail_code, fail_code2;
  logic [31:0] cycle_count, cycle_count2;
  logic [31:0] last_pc, last_pc2;

  test_status_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .retire      (retire),
    .pc          (pc),
    .mem_write   (mem_write),
    .data_addr   (data_addr),
    .write_data  (write_data),
    .status      (status),
    .done        (done),
    .hit_index   (hit_index),
    .fail_code   (fail_code),
    .cycle_count (cycle_count),
    .last_pc     (last_pc)
  );

  test_status_monitor #(
    .PASS_ADDRS     ({32'h30, 32'h14}),
    .MODE           (test_status_pkg::MODE_PC),
    .TIMEOUT_CYCLES (0)
  ) dut2 (
    .clk         (clk),
    .reset       (reset),
    .retire      (retire),
    .pc          (pc),
    .mem_write   (mem_write),
    .data_addr   (data_addr),
    .write_data  (write_data),
    .status      (status2),
    .done        (done2),
    .hit_index   (hit_index2),
    .fail_code   (fail_code2),
    .cycle_count (cycle_count2),
    .last_pc     (last_pc2)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_compared = 0;
  int n_mismatch = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    retire     = 1'b0;
    pc         = '0;
    mem_write  = 1'b0;
    data_addr  = '0;
    write_data = '0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_out(input logic [1:0] st, input logic hit, input logic [31:0] fc,
                            input logic [31:0] cnt, input logic [31:0] lpc);
    exp_q.push_back({st, hit, fc, cnt, lpc});
  endtask

  task automatic compare_out(input string tag);
    logic [W-1:0] e;
    check({tag, ".queued"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, ".status"},      status,      e[98:97]);
      check({tag, ".done"},        done,        (e[98:97] != S_RUN));
      check({tag, ".hit_index"},   hit_index,   e[96]);
      check({tag, ".fail_code"},   fail_code,   e[95:64]);
      check({tag, ".cycle_count"}, cycle_count, e[63:32]);
      check({tag, ".last_pc"},     last_pc,     e[31:0]);
    end
  endtask

  // Apply the currently driven inputs for one edge, then compare.
  task automatic cyc(input string tag, input logic [1:0] st, input logic hit,
                     input logic [31:0] fc, input logic [31:0] cnt, input logic [31:0] lpc);
    expect_out(st, hit, fc, cnt, lpc);
    step();
    idle_inputs();
    compare_out(tag);
  endtask

  // Reset with live-looking inputs. Reset must win over all of them.
  task automatic do_reset(input string tag);
    reset      = 1'b0;
    retire     = 1'b1;
    pc         = 32'h4C;
    mem_write  = 1'b1;
    data_addr  = 32'h1000;
    write_data = 32'h7;
    cyc(tag, S_RUN, 1'b0, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, status %0d", status);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset_initial");

    // pass at cycle 5, then stays sticky
    idle_n(5);
    retire = 1'b1; pc = 32'h14;
    cyc("pass_pc", S_PASS, 1'b0, 32'h0, 32'd5, 32'h14);
    retire = 1'b1; pc = 32'h4C; mem_write = 1'b1; data_addr = 32'h1000; write_data = 32'h3;
    cyc("pass_sticky", S_PASS, 1'b0, 32'h0, 32'd5, 32'h14);

    // fail via PC list, last_pc tracking
    do_reset("reset_from_pass");
    idle_n(2);
    retire = 1'b1; pc = 32'h20;
    cyc("retire_nohit", S_RUN, 1'b0, 32'h0, 32'd3, 32'h20);
    retire = 1'b1; pc = 32'h4C;
    cyc("fail_pc", S_FAIL, 1'b0, 32'h0, 32'd3, 32'h4C);
    cyc("fail_sticky", S_FAIL, 1'b0, 32'h0, 32'd3, 32'h4C);

    // simultaneous pc pass and tohost fail
    do_reset("reset_from_fail");
    retire = 1'b1; pc = 32'h14; mem_write = 1'b1; data_addr = 32'h1000; write_data = 32'h7;
    cyc("fail_beats_pass", S_FAIL, 1'b0, 32'h3, 32'd0, 32'h14);

    // tohost fail with a wide code
    do_reset("reset_b");
    idle_n(1);
    mem_write = 1'b1; data_addr = 32'h1000; write_data = 32'h8000_0001;
    cyc("tohost_fail", S_FAIL, 1'b0, 32'h4000_0000, 32'd1, 32'h0);

    // timeout at 70 cycles. dut2 has no timeout and must stay in RUN.
    do_reset("reset_c");
    idle_n(68);
    cyc("pre_timeout", S_RUN, 1'b0, 32'h0, 32'd69, 32'h0);
    cyc("timeout", S_TIMEOUT, 1'b0, 32'h0, 32'd69, 32'h0);
    idle_n(929);
    cyc("timeout_frozen", S_TIMEOUT, 1'b0, 32'h0, 32'd69, 32'h0);
    check("no_timeout.status", status2, S_RUN);
    check("no_timeout.done", done2, 1'b0);
    check("no_timeout.cycle_count", cycle_count2, 32'd1000);

    // pass beats timeout on the last counted cycle
    do_reset("reset_from_timeout");
    idle_n(69);
    retire = 1'b1; pc = 32'h14;
    cyc("pass_beats_timeout", S_PASS, 1'b0, 32'h0, 32'd69, 32'h14);

    // reset in the middle of a run
    do_reset("reset_d");
    for (int i = 0; i < 29; i++) begin
      retire = 1'b1; pc = 32'h100 + 32'(i);
      step();
    end
    retire = 1'b1; pc = 32'h11D;
    cyc("midrun", S_RUN, 1'b0, 32'h0, 32'd30, 32'h11D);
    do_reset("reset_midrun");
    idle_n(2);
    retire = 1'b1; pc = 32'h14;
    cyc("pass_after_reset", S_PASS, 1'b0, 32'h0, 32'd2, 32'h14);

    // tohost 0 is ignored, a wrong address is ignored, then 1 passes
    do_reset("reset_e");
    mem_write = 1'b1; data_addr = 32'h1000; write_data = 32'h0;
    cyc("tohost_zero", S_RUN, 1'b0, 32'h0, 32'd1, 32'h0);
    mem_write = 1'b1; data_addr = 32'h1004; write_data = 32'h1;
    cyc("tohost_wrong_addr", S_RUN, 1'b0, 32'h0, 32'd2, 32'h0);
    mem_write = 1'b1; data_addr = 32'h1000; write_data = 32'h1;
    cyc("tohost_pass", S_PASS, 1'b0, 32'h0, 32'd2, 32'h0);
    check("pc_mode_ignores_tohost", status2, S_RUN);
    retire = 1'b1; pc = 32'h30;
    cyc("pass_holds_30", S_PASS, 1'b0, 32'h0, 32'd2, 32'h0);
    check("pc_mode_pass.status", status2, S_PASS);
    check("pc_mode_pass.hit_index", hit_index2, 1'b1);
    check("pc_mode_pass.last_pc", last_pc2, 32'h30);
    retire = 1'b1; pc = 32'h4C;
    cyc("pass_holds_4c", S_PASS, 1'b0, 32'h0, 32'd2, 32'h0);
    check("pc_mode_sticky.status", status2, S_PASS);
    check("pc_mode_sticky.cycle_count", cycle_count2, 32'd3);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
